// File: rtl/window_serializer_pkg.sv
// Shared definitions for the 3x3 window serializer: pixel width, window size and FSM states.
package window_serializer_pkg;

  localparam int DATA_BIT_WIDTH = 4;
  localparam int CHANNELS       = 3;
  localparam int PIXW           = DATA_BIT_WIDTH * CHANNELS;
  localparam int WIN_TAPS       = 9;
  localparam int BEAT_W         = $clog2(WIN_TAPS);

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

endpackage

// File: rtl/window_serializer_line_buffer.sv
// One row of pixels: combinational read and registered write at the same column address.
module window_serializer_line_buffer
  import window_serializer_pkg::*;
#(
  parameter int Depth = 16,
  parameter int Width = PIXW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(Depth)-1:0] addr,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  output logic [Width-1:0]         rd_data
);

  logic [Width-1:0] mem [Depth];

  assign rd_data = mem[addr];

  // Store the pixel at the current column; the whole row clears on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_serializer.sv
// Raster pixel stream in, every complete 3x3 neighbourhood out as 9 serial enable beats.
module window_serializer
  import window_serializer_pkg::*;
#(
  parameter int DataBitWidth = DATA_BIT_WIDTH,
  parameter int Channels     = CHANNELS,
  parameter int LineWidth    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sof,
  input  logic [DataBitWidth*Channels-1:0] in_data,
  output logic                             buf_en,
  output logic [DataBitWidth*Channels-1:0] buf_data,
  output logic                             win_valid
);

  localparam int PixW = DataBitWidth * Channels;
  localparam int ColW = $clog2(LineWidth);
  localparam logic [ColW-1:0]   LastCol  = ColW'(LineWidth - 1);
  localparam logic [ColW-1:0]   FirstWin = ColW'(2);
  localparam logic [1:0]        LastRow  = 2'd2;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(WIN_TAPS - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ColW-1:0]   col_q, cur_col, next_col;
  logic [1:0]        row_q, cur_row, next_row;
  logic              accept, win_done;
  logic [PixW-1:0]   lb0_rd, lb1_rd;
  logic [PixW-1:0]   win_q [WIN_TAPS];
  logic [PixW-1:0]   win_d [WIN_TAPS];

  assign accept = in_valid && in_ready;

  // Position of the pixel being offered; sof restarts it at row 0 col 0
  always_comb begin
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    next_col = (cur_col == LastCol) ? '0 : cur_col + ColW'(1);
    next_row = cur_row;
    if ((cur_col == LastCol) && (cur_row != LastRow)) begin
      next_row = cur_row + 2'd1;
    end
    win_done = (cur_row == LastRow) && (cur_col >= FirstWin);
  end

  // lb0 holds the row two above, lb1 the row directly above
  window_serializer_line_buffer #(
    .Depth(LineWidth),
    .Width(PixW)
  ) lb0 (
    .clk    (clk),
    .rst    (rst),
    .addr   (cur_col),
    .wr_en  (accept),
    .wr_data(lb1_rd),
    .rd_data(lb0_rd)
  );

  window_serializer_line_buffer #(
    .Depth(LineWidth),
    .Width(PixW)
  ) lb1 (
    .clk    (clk),
    .rst    (rst),
    .addr   (cur_col),
    .wr_en  (accept),
    .wr_data(in_data),
    .rd_data(lb1_rd)
  );

  // Window shifted left by one column with the new column entering on the right
  always_comb begin
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = lb0_rd;
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = lb1_rd;
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = in_data;
  end

  // Position counters and window columns advance only on an accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
    end else if (accept) begin
      col_q <= next_col;
      row_q <= next_row;
      win_q <= win_d;
    end
  end

  // FSM state and beat counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCEPT;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next state: a completed window locks out input for the 9 emit beats
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    in_ready = 1'b0;
    case (state_q)
      ACCEPT: begin
        in_ready = 1'b1;
        if (accept && win_done) begin
          state_d = EMIT;
          beat_d  = '0;
        end
      end
      EMIT: begin
        if (beat_q == LastBeat) begin
          state_d = ACCEPT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = ACCEPT;
        beat_d  = '0;
      end
    endcase
  end

  // Registered outputs: beat 0 comes from the freshly shifted window, later beats from the held one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_en    <= 1'b0;
      buf_data  <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      case (state_q)
        ACCEPT: begin
          if (accept && win_done) begin
            buf_en   <= 1'b1;
            buf_data <= win_d[0];
          end
        end
        EMIT: begin
          if (beat_q == LastBeat) begin
            buf_en    <= 1'b0;
            win_valid <= 1'b1;
          end else begin
            buf_data <= win_q[beat_d];
          end
        end
        default: buf_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer with a frame-level reference model (LineWidth=4).
module tb_window_serializer;

  localparam int DW = 4;
  localparam int CH = 3;
  localparam int LW = 4;
  localparam int PW = DW * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_ready;
  logic          buf_en;
  logic [PW-1:0] buf_data;
  logic          win_valid;

  always #5 clk = ~clk;

  window_serializer #(
    .DataBitWidth(DW),
    .Channels    (CH),
    .LineWidth   (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .buf_en   (buf_en),
    .buf_data (buf_data),
    .win_valid(win_valid)
  );

  // Reference model: pixels of the current frame plus the schedule of upcoming output cycles
  typedef struct {
    logic          en;
    logic [PW-1:0] data;
    logic          wv;
  } slot_t;

  typedef struct {
    logic          v;
    logic [PW-1:0] d;
    logic          expReady;
    logic          expEn;
    logic [PW-1:0] expData;
    logic          expWv;
  } vec_t;

  slot_t         sched[$];
  logic [PW-1:0] frame[$];
  logic [PW-1:0] lastData = '0;
  logic          lastAccept = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    sched.delete();
    frame.delete();
    lastData = '0;
  endtask

  // Pixel n of a frame sits at row n/LW, col n%LW; a window exists once row>=2 and col>=2
  task automatic modelAccept(input logic sof, input logic [PW-1:0] d);
    int n;
    int r;
    int c;
    if (sof) frame.delete();
    frame.push_back(d);
    n = frame.size() - 1;
    r = n / LW;
    c = n % LW;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sched.push_back('{en: 1'b1, data: frame[(r - 2 + i) * LW + (c - 2 + j)], wv: 1'b0});
        end
      end
      sched.push_back('{en: 1'b0, data: '0, wv: 1'b1});
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and clock
  task automatic applyStimulus(input logic v, input logic s, input logic [PW-1:0] d);
    logic          expReady;
    logic          expEn;
    logic          expWv;
    logic [PW-1:0] expData;
    slot_t         head;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    expReady = (sched.size() == 0) || !sched[0].en;
    expEn    = (sched.size() != 0) && sched[0].en;
    expWv    = (sched.size() != 0) && sched[0].wv;
    expData  = expEn ? sched[0].data : lastData;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("buf_en", 32'(buf_en), 32'(expEn));
    checkOutput("buf_data", 32'(buf_data), 32'(expData));
    checkOutput("win_valid", 32'(win_valid), 32'(expWv));
    lastAccept = v && expReady;
    if (sched.size() != 0) begin
      head = sched.pop_front();
      if (head.en) lastData = head.data;
    end
    if (lastAccept) modelAccept(s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  // Offer pixels every cycle until the first burst beat is visible; returns accepts taken (-1 on timeout)
  task automatic feedUntilBurst(input logic firstSof, input logic useConst, input logic [PW-1:0] constVal,
                                output int accepts);
    int acc;
    bit seen;
    acc  = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (buf_en) begin
        seen = 1'b1;
        break;
      end
      applyStimulus(1'b1, firstSof && (acc == 0), useConst ? constVal : PW'($urandom));
      if (lastAccept) acc++;
    end
    accepts = seen ? acc : -1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[22];
    logic [3:0]    rowCh0[3];
    logic [3:0]    beatCh0[9];
    int            acc;
    int            wvAt;
    int            lowReady;
    int            enCount;
    int            wvCount;
    logic [PW-1:0] nextVal;

    rowCh0  = '{4'd0, 4'd1, 4'd3};
    beatCh0 = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd3};
    for (int i = 0; i < 22; i++) begin
      vecs[i].v        = (i < 11);
      vecs[i].d        = (i < 11) ? {8'hAA, rowCh0[i / LW]} : '0;
      vecs[i].expReady = (i < 11) || (i >= 20);
      vecs[i].expEn    = (i >= 11) && (i < 20);
      vecs[i].expData  = (i < 11) ? '0 : (i < 20) ? {8'hAA, beatCh0[i - 11]} : {8'hAA, 4'd3};
      vecs[i].expWv    = (i == 20);
    end

    // Reset held with in_valid high: idle outputs and nothing accepted
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_buf_en", 32'(buf_en), 32'd0);
      checkOutput("rst_buf_data", 32'(buf_data), 32'd0);
      checkOutput("rst_win_valid", 32'(win_valid), 32'd0);
    end
    rst = 1'b1;
    modelClear();

    // Table: rows ch0 = 0,1,3 with no sof right after reset
    $display("[TB] table-driven row pattern");
    for (int i = 0; i < 22; i++) begin
      checkOutput("tbl_in_ready", 32'(in_ready), 32'(vecs[i].expReady));
      checkOutput("tbl_buf_en", 32'(buf_en), 32'(vecs[i].expEn));
      checkOutput("tbl_buf_data", 32'(buf_data), 32'(vecs[i].expData));
      checkOutput("tbl_win_valid", 32'(win_valid), 32'(vecs[i].expWv));
      applyStimulus(vecs[i].v, 1'b0, vecs[i].d);
    end

    // Flat 0x555 frame with sof: burst after the 11th accept, win_valid 10 cycles after it
    $display("[TB] flat frame");
    feedUntilBurst(1'b1, 1'b1, 12'h555, acc);
    checkOutput("flat_accepts_before_burst", 32'(acc), 32'd11);
    wvAt = -1;
    for (int j = 1; j <= 12; j++) begin
      if (win_valid && wvAt < 0) wvAt = j;
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("flat_win_valid_cycle", 32'(wvAt), 32'd10);

    // Backpressure: in_valid held high, incrementing data, four rows
    $display("[TB] backpressure");
    lowReady = 0;
    enCount  = 0;
    wvCount  = 0;
    acc      = 0;
    nextVal  = 12'h100;
    for (int cyc = 0; cyc < 300 && acc < 16; cyc++) begin
      if (!in_ready) lowReady++;
      if (buf_en) enCount++;
      if (win_valid) wvCount++;
      applyStimulus(1'b1, acc == 0, nextVal);
      if (lastAccept) begin
        acc++;
        nextVal = nextVal + 12'd1;
      end
    end
    for (int j = 0; j < 12; j++) begin
      if (!in_ready) lowReady++;
      if (buf_en) enCount++;
      if (win_valid) wvCount++;
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("bp_accepts", 32'(acc), 32'd16);
    checkOutput("bp_ready_low_cycles", 32'(lowReady), 32'd36);
    checkOutput("bp_beats", 32'(enCount), 32'd36);
    checkOutput("bp_windows", 32'(wvCount), 32'd4);

    // Reset asserted during beat 4 of a burst
    $display("[TB] reset mid-burst");
    feedUntilBurst(1'b1, 1'b0, '0, acc);
    checkOutput("mr_accepts_before_burst", 32'(acc), 32'd11);
    drain(4);
    checkOutput("mr_beat4_en", 32'(buf_en), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mr_en_drop", 32'(buf_en), 32'd0);
    checkOutput("mr_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      checkOutput("mr_no_win_valid", 32'(win_valid), 32'd0);
    end
    rst = 1'b1;
    modelClear();
    feedUntilBurst(1'b0, 1'b0, '0, acc);
    checkOutput("mr_accepts_after_release", 32'(acc), 32'd11);
    drain(12);

    // sof arriving where row 3 col 2 would be restarts counting
    $display("[TB] sof mid-row");
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 14; cyc++) begin
      applyStimulus(1'b1, acc == 0, PW'($urandom));
      if (lastAccept) acc++;
    end
    checkOutput("sof_pre_accepts", 32'(acc), 32'd14);
    drain(12);
    feedUntilBurst(1'b1, 1'b0, '0, acc);
    checkOutput("sof_accepts_before_burst", 32'(acc), 32'd11);
    drain(12);

    // Random traffic against the model
    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 500; cyc++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, PW'($urandom));
    end
    drain(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
